// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Time-multiplexed scanner for a 4-digit common-anode seven-segment panel.
// Digit codes are snapshotted once per frame so a frame never mixes old and
// new values. Each digit slot opens with a dead-time where all anodes are off,
// which suppresses ghosting. It is followed by a brightness-scaled on-window.
// A free-running blink phase can blank the whole display.
//
// Parameters:
//   REFRESH_DIV  - clock cycles per digit slot (keep >= BLANK_CYCLES + 8)
//   BLANK_CYCLES - dead-time cycles at the start of every slot
//   BLINK_DIV    - clock cycles per blink half-period
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   digit3..0   active-low segment codes {g..a}; digit3 is leftmost
//   dp_mask     decimal point enable per digit, active-high, bit i = digit i
//   brightness  0 = dimmest, 7 = full on-window (sampled every cycle)
//   blink_en    blank the whole display during the odd blink phase
//   seg         cathodes, active-low, registered
//   dp          decimal-point cathode, active-low, registered
//   an          anodes, active-low, registered; an[i] selects digit i
//   frame_tick  one-cycle pulse as each new frame starts, registered
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] digit3,
    input  logic [6:0] digit2,
    input  logic [6:0] digit1,
    input  logic [6:0] digit0,
    input  logic [3:0] dp_mask,
    input  logic [2:0] brightness,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    // The on-window arithmetic runs 40 bits wide so ON*(brightness+1) is
    // never truncated before the divide-by-8.
    localparam logic [39:0] BLANK_X = 40'(BLANK_CYCLES);
    localparam logic [39:0] ON_X    = 40'(REFRESH_DIV - BLANK_CYCLES);

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_phase_reg;
    logic          load_pending_reg;

    logic          slot_end;
    logic          frame_end;
    logic          capture;

    logic [27:0]   digit_flat;
    logic [27:0]   snap_flat;
    logic [3:0]    dp_snap;

    logic [39:0]   cnt_x;
    logic [39:0]   lit_prod;
    logic [39:0]   lit_len;
    logic          lit;
    logic [6:0]    cur_seg;

    logic [6:0]    seg_next;
    logic          dp_next;
    logic [3:0]    an_next;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == 2'd3);
    // The priming capture after reset makes the first frame show live data
    // rather than the blank reset snapshot.
    assign capture   = load_pending_reg || frame_end;

    assign digit_flat = {digit3, digit2, digit1, digit0};

    // Per-digit snapshot registers: segment code plus decimal-point enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [6:0] snap_reg;
        logic       dp_snap_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                snap_reg    <= 7'h7F;
                dp_snap_reg <= 1'b0;
            end else if (capture) begin
                snap_reg    <= digit_flat[gi*7 +: 7];
                dp_snap_reg <= dp_mask[gi];
            end
        end

        assign snap_flat[gi*7 +: 7] = snap_reg;
        assign dp_snap[gi]          = dp_snap_reg;
    end

    always_comb begin
        cur_seg = 7'h7F;
        case (idx_reg)
            2'd0: cur_seg = snap_flat[6:0];
            2'd1: cur_seg = snap_flat[13:7];
            2'd2: cur_seg = snap_flat[20:14];
            2'd3: cur_seg = snap_flat[27:21];
            default: cur_seg = 7'h7F;
        endcase
    end

    // On-window length LIT = ON*(brightness+1)/8. The window starts right
    // after the dead-time, so the slot length never depends on brightness.
    assign cnt_x    = 40'(cnt_reg);
    assign lit_prod = ON_X * {37'd0, brightness} + ON_X;
    assign lit_len  = lit_prod >> 3;
    assign lit      = (cnt_x >= BLANK_X) && ((cnt_x - BLANK_X) < lit_len)
                      && !(blink_en && blink_phase_reg);

    // Cathodes are forced blank whenever the anodes are off.
    always_comb begin
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        an_next  = 4'b1111;
        if (lit) begin
            an_next  = ~(4'b0001 << idx_reg);
            seg_next = cur_seg;
            dp_next  = ~dp_snap[idx_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg          <= '0;
            idx_reg          <= 2'd0;
            blink_cnt_reg    <= '0;
            blink_phase_reg  <= 1'b0;
            load_pending_reg <= 1'b1;
            seg              <= 7'h7F;
            dp               <= 1'b1;
            an               <= 4'b1111;
            frame_tick       <= 1'b0;
        end else begin
            load_pending_reg <= 1'b0;

            if (slot_end) begin
                cnt_reg <= '0;
                idx_reg <= idx_reg + 2'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            // Blink timebase runs continuously so the phase is independent
            // of when blink_en is raised.
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end

            // Only the end-of-frame capture pulses the tick. The priming
            // capture always happens with idx at 0, so it never does.
            frame_tick <= frame_end;
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux (REFRESH_DIV=16, BLANK_CYCLES=2, BLINK_DIV=64).
// The stimulus pushes the expected lit runs of each frame into a queue:
// anode, segment code, dp and number of lit cycles. A monitor samples the
// outputs on the falling edge. It assembles each contiguous lit run and pops
// and compares it when the run ends. The monitor also checks the anode and
// blanking invariants, the inter-digit dead-time and frame_tick placement.
module tb_seg_scan_mux;

    localparam int RD = 16;
    localparam int BC = 2;
    localparam int BD = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] digit3, digit2, digit1, digit0;
    logic [3:0] dp_mask;
    logic [2:0] brightness;
    logic       blink_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .BLINK_DIV   (BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0),
        .dp_mask   (dp_mask),
        .brightness(brightness),
        .blink_en  (blink_en),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [7:0] len;
    } run_t;

    run_t exp_q[$];
    run_t cur;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   tick_count = 0;
    int   gap = 0;
    bit   started = 1'b0;
    bit   in_run = 1'b0;
    bit   have_prev = 1'b0;

    // cyc equals k while output cycle k (k-th edge after reset release) is visible.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: got time limit reached, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic finish_run();
        run_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL run_unexpected: got an=%b seg=%h dp=%b len=%0d at cyc %0d, required no run",
                     cur.an, cur.seg, cur.dp, cur.len, cyc);
        end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
                errors++;
                $display("FAIL run: got an=%b seg=%h dp=%b len=%0d, required an=%b seg=%h dp=%b len=%0d (cyc %0d)",
                         cur.an, cur.seg, cur.dp, cur.len, e.an, e.seg, e.dp, e.len, cyc);
            end else begin
                $display("run ok: an=%b seg=%h dp=%b len=%0d ended at cyc %0d",
                         cur.an, cur.seg, cur.dp, cur.len, cyc);
            end
        end
        in_run    = 1'b0;
        have_prev = 1'b1;
        gap       = 0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (started) begin
                checks++;
                if ((an != 4'b1111 && $countones(~an) != 1) ||
                    (an == 4'b1111 && (seg != 7'h7F || dp != 1'b1))) begin
                    errors++;
                    $display("FAIL invariant: got an=%b seg=%h dp=%b at cyc %0d, required one anode max and blank cathodes when dark",
                             an, seg, dp, cyc);
                end

                if (an == 4'b1111) begin
                    if (in_run) finish_run();
                    gap++;
                end else if (in_run && an == cur.an && seg == cur.seg && dp == cur.dp) begin
                    cur.len++;
                end else begin
                    if (in_run) finish_run();
                    if (have_prev) begin
                        checks++;
                        if (gap < BC) begin
                            errors++;
                            $display("FAIL dead_time: got %0d dark cycles before an=%b at cyc %0d, required >= %0d",
                                     gap, an, cyc, BC);
                        end
                    end
                    cur.an  = an;
                    cur.seg = seg;
                    cur.dp  = dp;
                    cur.len = 8'd1;
                    in_run  = 1'b1;
                end

                if (frame_tick) begin
                    tick_count++;
                    checks++;
                    if (cyc == 0 || (cyc % (4 * RD)) != 0) begin
                        errors++;
                        $display("FAIL frame_tick: got pulse at cyc %0d, required a nonzero multiple of %0d",
                                 cyc, 4 * RD);
                    end else begin
                        $display("tick ok: frame_tick at cyc %0d", cyc);
                    end
                end

                if (rst) have_prev = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("check ok: %s = %h", name, got);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: got cyc %0d, required %0d", cyc, n);
        end
    endtask

    task automatic push_run(input logic [3:0] a, input logic [6:0] s, input logic d, input logic [7:0] l);
        run_t r;
        r.an  = a;
        r.seg = s;
        r.dp  = d;
        r.len = l;
        exp_q.push_back(r);
    endtask

    // One full frame in scan order digit0..digit3; dp is active-low per dp_mask.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpm, input logic [7:0] l);
        push_run(4'b1110, s0, ~dpm[0], l);
        push_run(4'b1101, s1, ~dpm[1], l);
        push_run(4'b1011, s2, ~dpm[2], l);
        push_run(4'b0111, s3, ~dpm[3], l);
    endtask

    initial begin : stimulus
        digit0     = 7'h40;
        digit1     = 7'h79;
        digit2     = 7'h24;
        digit3     = 7'h30;
        dp_mask    = 4'b0100;
        brightness = 3'd7;
        blink_en   = 1'b0;

        #1 rst = 1'b1;
        started = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an), 32'h0000000F);
        check("reset_seg", 32'(seg), 32'h0000007F);
        check("reset_dp", 32'(dp), 32'h00000001);
        check("reset_frame_tick", 32'(frame_tick), 32'h00000000);

        // Frame 0: full brightness, dp on digit2 only.
        push_frame(7'h40, 7'h79, 7'h24, 7'h30, 4'b0100, 8'd14);
        rst = 1'b0;

        // Frame 1: digit2 changes while slot 0 is scanning; still shows 24.
        wait_cyc(64);
        push_frame(7'h40, 7'h79, 7'h24, 7'h30, 4'b0100, 8'd14);
        wait_cyc(70);
        digit2 = 7'h12;

        // Frame 2: new digit2 value appears after the frame boundary.
        wait_cyc(128);
        push_frame(7'h40, 7'h79, 7'h12, 7'h30, 4'b0100, 8'd14);

        // Frame 3: brightness 3 -> 14*4/8 = 7 lit cycles.
        wait_cyc(192);
        brightness = 3'd3;
        push_frame(7'h40, 7'h79, 7'h12, 7'h30, 4'b0100, 8'd7);

        // Frame 4: brightness 0 -> 14*1/8 = 1 lit cycle.
        wait_cyc(256);
        brightness = 3'd0;
        push_frame(7'h40, 7'h79, 7'h12, 7'h30, 4'b0100, 8'd1);

        // Frame 5: blink odd phase -> completely dark, nothing expected.
        wait_cyc(320);
        brightness = 3'd7;
        blink_en   = 1'b1;

        // Frame 6: blink even phase -> normal scan.
        wait_cyc(384);
        push_frame(7'h40, 7'h79, 7'h12, 7'h30, 4'b0100, 8'd14);

        // Frame 7: dark; blink cleared in slot 1 at cnt 4 -> 12 lit cycles remain.
        wait_cyc(468);
        blink_en = 1'b0;
        push_run(4'b1101, 7'h79, 1'b1, 8'd12);
        push_run(4'b1011, 7'h12, 1'b0, 8'd14);
        push_run(4'b0111, 7'h30, 1'b1, 8'd14);

        // Frame 8: reset lands 5 cycles into the slot-1 on-window.
        wait_cyc(512);
        push_run(4'b1110, 7'h40, 1'b1, 8'd14);
        push_run(4'b1101, 7'h79, 1'b1, 8'd5);
        wait_cyc(535);
        #2;
        check("pre_reset_an", 32'(an), 32'h0000000D);
        rst = 1'b1;
        #1;
        check("midframe_reset_an", 32'(an), 32'h0000000F);
        check("midframe_reset_seg", 32'(seg), 32'h0000007F);
        check("midframe_reset_dp", 32'(dp), 32'h00000001);
        repeat (3) @(negedge clk);

        // First frame after release shows the values captured right after release.
        push_frame(7'h40, 7'h79, 7'h12, 7'h30, 4'b0100, 8'd14);
        rst = 1'b0;
        wait_cyc(70);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("tick_count", 32'(tick_count), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
